// File: rtl/rr_stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

    // Packet-lock FSM states (only built when packet locking is enabled)
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_stream_mux_pick.sv
// Round-robin picker: double-width masked priority encoder.
// Requests are duplicated side by side. Only the window [ptr, ptr+N_CH) is
// searched, so the lowest set bit in that window is the first requester at
// or after ptr, with wrap-around handled for any N_CH.
module rr_pick #(
    parameter int N_CH  = 16,
    parameter int SEL_W = 4
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [2*N_CH-1:0] dbl;
    logic [2*N_CH-1:0] masked;

    // Mask the doubled request vector to the search window, then take its lowest bit
    always_comb begin
        dbl     = {req, req};
        masked  = '0;
        gnt_any = |req;
        gnt_idx = '0;
        for (int i = 0; i < 2*N_CH; i++) begin
            masked[i] = dbl[i] && (i >= int'(ptr)) && (i < int'(ptr) + N_CH);
        end
        for (int i = 2*N_CH-1; i >= 0; i--) begin
            if (masked[i]) begin
                gnt_idx = (i >= N_CH) ? SEL_W'(i - N_CH) : SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel round-robin stream multiplexer with a registered output stage.
// Optional packet locking is enabled by defining RR_STREAM_MUX_PKT_LOCK_EN:
// once a channel starts a packet, it keeps the grant until its last beat.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int WIDTH = 8,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic             load;
    logic             xfer;
    logic             ptr_upd;
    logic [N_CH-1:0]  req;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             gnt_last;
    logic [WIDTH-1:0] gnt_data;

    // The output register can take a new beat when empty or draining this cycle
    assign load = !out_valid || out_ready;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    lock_state_e      state;
    lock_state_e      state_next;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] lock_ch_next;

    // While locked, only the channel owning the open packet may request
    assign req     = (state == LOCKED) ? (in_valid & (N_CH'(1) << lock_ch)) : in_valid;
    // The pointer only advances at packet boundaries
    assign ptr_upd = gnt_last;

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            state   <= state_next;
            lock_ch <= lock_ch_next;
        end
    end

    // Lock FSM next state: lock on a non-last beat, release on the last beat
    always_comb begin
        state_next   = state;
        lock_ch_next = lock_ch;
        case (state)
            IDLE: begin
                if (xfer && !gnt_last) begin
                    state_next   = LOCKED;
                    lock_ch_next = gnt_idx;
                end
            end
            LOCKED: begin
                if (xfer && gnt_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
`else
    assign req     = in_valid;
    assign ptr_upd = 1'b1;
`endif

    rr_pick #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign xfer     = load && gnt_any && !rst;
    assign in_ready = xfer ? (N_CH'(1) << gnt_idx) : '0;
    assign ptr_next = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;

    // Select the granted channel's payload with constant slices only
    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
                gnt_last = in_last[i];
            end
        end
    end

    // Output register and round-robin pointer; everything holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
        end else if (load) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_sel   <= gnt_idx;
                out_last  <= gnt_last;
                if (ptr_upd) begin
                    ptr <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed testbench for rr_stream_mux: a 16-channel and a 5-channel instance.
module tb_rr_stream_mux;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // 16-channel instance
    logic [16*8-1:0] a_data;
    logic [15:0]     a_valid, a_last, a_ready;
    logic [7:0]      a_odata;
    logic [3:0]      a_osel;
    logic            a_olast, a_ovalid, a_oready;

    // 5-channel instance
    logic [5*8-1:0]  b_data;
    logic [4:0]      b_valid, b_last, b_ready;
    logic [7:0]      b_odata;
    logic [2:0]      b_osel;
    logic            b_olast, b_ovalid, b_oready;

    rr_stream_mux #(.N_CH(16), .WIDTH(8)) u_a (
        .clk(clk), .rst(rst),
        .in_data(a_data), .in_valid(a_valid), .in_last(a_last), .in_ready(a_ready),
        .out_data(a_odata), .out_sel(a_osel), .out_last(a_olast),
        .out_valid(a_ovalid), .out_ready(a_oready)
    );

    rr_stream_mux #(.N_CH(5), .WIDTH(8)) u_b (
        .clk(clk), .rst(rst),
        .in_data(b_data), .in_valid(b_valid), .in_last(b_last), .in_ready(b_ready),
        .out_data(b_odata), .out_sel(b_osel), .out_last(b_olast),
        .out_valid(b_ovalid), .out_ready(b_oready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_rdy;
        int          ch;

        for (int i = 0; i < 16; i++) a_data[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 5; i++)  b_data[i*8 +: 8] = 8'h50 + 8'(i);
        rst      = 1'b1;
        a_valid  = 16'hFFFF;
        a_last   = '0;
        a_oready = 1'b1;
        b_valid  = 5'h1F;
        b_last   = '0;
        b_oready = 1'b1;

        // Reset with every channel valid
        #1;
        check("rst_ready_a0", 64'(a_ready), 64'h0);
        check("rst_ready_b0", 64'(b_ready), 64'h0);
        tick();
        check("rst_ready_a1", 64'(a_ready), 64'h0);
        check("rst_valid_a1", 64'(a_ovalid), 64'h0);
        tick();
        check("rst_ready_a2", 64'(a_ready), 64'h0);
        check("rst_valid_a2", 64'(a_ovalid), 64'h0);
        check("rst_valid_b2", 64'(b_ovalid), 64'h0);
        rst     = 1'b0;
        b_valid = '0;
        #1;
        check("first_ready", 64'(a_ready), 64'h0001);

        // Fairness: all valid, out_ready high, expect 0..15,0 with no bubbles
        for (int k = 0; k <= 16; k++) begin
            tick();
            ch      = k % 16;
            exp_rdy = 16'h1 << ((k + 1) % 16);
            check("fair_valid", 64'(a_ovalid), 64'h1);
            check("fair_sel", 64'(a_osel), 64'(ch));
            check("fair_data", 64'(a_odata), 64'(8'h10 + 8'(ch)));
            check("fair_ready", 64'(a_ready), 64'(exp_rdy));
        end

        // Backpressure: hold 0xA5 on the output for three stalled cycles
        a_valid = 16'h0008;
        a_data[3*8 +: 8] = 8'hA5;
        tick();
        check("bp_load_sel", 64'(a_osel), 64'h3);
        check("bp_load_data", 64'(a_odata), 64'hA5);
        a_oready = 1'b0;
        a_valid  = 16'h0020;
        #1;
        check("bp_ready0", 64'(a_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_data", 64'(a_odata), 64'hA5);
            check("bp_hold_valid", 64'(a_ovalid), 64'h1);
            check("bp_hold_ready", 64'(a_ready), 64'h0);
        end
        a_oready = 1'b1;
        #1;
        check("bp_release_ready", 64'(a_ready), 64'h0020);
        tick();
        check("bp_next_valid", 64'(a_ovalid), 64'h1);
        check("bp_next_sel", 64'(a_osel), 64'h5);
        check("bp_next_data", 64'(a_odata), 64'h15);

        // Empty load: valid drops, data and sel hold
        a_valid = '0;
        tick();
        check("empty_valid", 64'(a_ovalid), 64'h0);
        check("empty_data", 64'(a_odata), 64'h15);
        check("empty_sel", 64'(a_osel), 64'h5);

        // Mid-operation reset drops the held beat and clears the pointer
        a_valid = 16'h0100;
        tick();
        check("mr_load_sel", 64'(a_osel), 64'h8);
        a_oready = 1'b0;
        a_valid  = '0;
        tick();
        check("mr_stall_valid", 64'(a_ovalid), 64'h1);
        rst = 1'b1;
        a_valid = 16'hFFFF;
        #1;
        check("mr_rst_ready", 64'(a_ready), 64'h0);
        tick();
        check("mr_valid", 64'(a_ovalid), 64'h0);
        check("mr_sel", 64'(a_osel), 64'h0);
        check("mr_data", 64'(a_odata), 64'h0);
        rst = 1'b0;
        #1;
        check("mr_ptr0", 64'(a_ready), 64'h0001);
        a_valid  = '0;
        a_oready = 1'b1;

        // Non-power-of-two wrap: get ptr to 4, then ch1/ch4 alternate
        b_valid = 5'b01000;
        #1;
        check("wrap_ready_ch3", 64'(b_ready), 64'h08);
        tick();
        check("wrap_sel3", 64'(b_osel), 64'h3);
        b_valid = 5'b10010;
        #1;
        check("wrap_ready_a", 64'(b_ready), 64'h10);
        tick();
        check("wrap_sel4a", 64'(b_osel), 64'h4);
        check("wrap_data4a", 64'(b_odata), 64'h54);
        check("wrap_ready_b", 64'(b_ready), 64'h02);
        tick();
        check("wrap_sel1", 64'(b_osel), 64'h1);
        check("wrap_data1", 64'(b_odata), 64'h51);
        check("wrap_ready_c", 64'(b_ready), 64'h10);
        tick();
        check("wrap_sel4b", 64'(b_osel), 64'h4);
        b_valid = '0;
        tick();

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch2 sends three beats while ch7 waits
        a_valid = 16'h0084;
        a_last  = '0;
        a_data[2*8 +: 8] = 8'h21;
        #1;
        check("lock_ready1", 64'(a_ready), 64'h0004);
        tick();
        check("lock_sel1", 64'(a_osel), 64'h2);
        a_data[2*8 +: 8] = 8'h22;
        #1;
        check("lock_ready2", 64'(a_ready), 64'h0004);
        tick();
        check("lock_sel2", 64'(a_osel), 64'h2);
        check("lock_data2", 64'(a_odata), 64'h22);
        a_data[2*8 +: 8] = 8'h23;
        a_last[2] = 1'b1;
        #1;
        check("lock_ready3", 64'(a_ready), 64'h0004);
        tick();
        check("lock_sel3", 64'(a_osel), 64'h2);
        check("lock_last3", 64'(a_olast), 64'h1);
        a_valid = 16'h0080;
        a_last  = '0;
        #1;
        check("lock_ready7", 64'(a_ready), 64'h0080);
        tick();
        check("lock_sel7", 64'(a_osel), 64'h7);
        a_valid = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, WIDTH-bit streaming multiplexer with per-channel valid/ready handshakes and round-robin arbitration.
- Sits where our fixed 2/4/8/16:1 select muxes cannot: many producers share one consumer, and no external select drives the choice.
- The output is registered, so each accepted beat appears on the output one cycle after acceptance.
- Reports which channel won on the same cycle as the data.

Parameters:
- N_CH, 16, number of input channels (2..64; non-power-of-two allowed)
- WIDTH, 8, data bits per channel
- SEL_W, $clog2(N_CH), width of the channel index (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N_CH  per-channel beat valid
- in_last  in  N_CH  per-channel end-of-packet flag, carried with the beat
- in_ready  out  N_CH  per-channel accept; at most one bit high (one-hot or zero)
- out_data  out  WIDTH  registered data of the winning beat
- out_sel  out  SEL_W  registered index of the winning channel
- out_last  out  1  registered in_last of the winning beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, round-robin pointer ptr=0, lock state=IDLE. in_ready=0 in every cycle where rst=1.
- load = !out_valid || out_ready. This is a combinational function of output state plus out_ready.
- Grant: the first channel g with in_valid[g]=1, searching from ptr upward and wrapping from N_CH-1 to 0.
  - in_ready[g] = load && eligible(g). All other in_ready bits are 0.
  - in_ready never depends on in_data.
- Transfer at the clock edge (load && grant exists):
  - out_data <= in_data[g]
  - out_sel <= g
  - out_last <= in_last[g]
  - out_valid <= 1
  - ptr <= (g==N_CH-1) ? 0 : g+1
- Empty load (load && no eligible valid): out_valid <= 0. Data, sel and last hold their previous values.
- Stall (out_valid && !out_ready): all output registers and ptr hold; in_ready=0.
- Latency: 1 cycle from input acceptance to out_valid. Sustained throughput is 1 beat/cycle when out_ready=1.
- Fairness: a continuously valid channel waits at most N_CH-1 granted beats.
- Simultaneous events:
  - out_ready=1 with a new grant in the same cycle: the old beat leaves and the new beat loads. No bubble.
  - Two or more valid channels: exactly one is granted, per the ptr order.
- Reset mid-operation: any beat held in the output register is dropped. Producers see in_ready=0 during reset, so no beat is accepted.
- Inputs on non-granted channels must hold (valid-stable protocol). The block does not check this.

Optional Feature:
- Macro: RR_STREAM_MUX_PKT_LOCK_EN.
- Defined: a two-state lock FSM with states IDLE and LOCKED, plus lock_ch [SEL_W-1:0].
  - IDLE: all channels eligible.
  - IDLE -> LOCKED: a transfer with in_last[g]=0; lock_ch <= g.
  - LOCKED: only lock_ch is eligible; other channels get in_ready=0 even when valid.
  - LOCKED -> IDLE: a transfer with in_last[lock_ch]=1.
  - ptr updates only on transfers with last=1. ptr is not updated on mid-packet beats.
  - Reset forces IDLE.
- Undefined: every transfer is arbitrated independently. in_last is only passed through to out_last. The FSM and lock_ch are not built.

Decomposition:
- Package rr_stream_mux_pkg holds:
  - lock_state_e enum (IDLE, LOCKED)
  - localparam function clog2_min1 (returns at least 1 for SEL_W)
- Sub-module rr_pick (combinational): inputs req[N_CH] and ptr[SEL_W]; outputs gnt_idx[SEL_W] and gnt_any.
  - Implemented as a double-width masked priority encoder. This is the natural generalisation of our fixed select muxes.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all in_valid=1 -> in_ready=0 and out_valid=0 throughout; after release, first out_sel=0.
- Fairness: N_CH=16, all channels valid, out_ready=1 -> out_sel sequence 0,1,...,15,0 with no bubbles.
- Wrap with non-power-of-two: N_CH=5, ptr=4, valid={ch1,ch4} -> grant 4, then 1, then 4.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data=0xA5 -> out_data holds 0xA5, in_ready=0; on release, next beat loads the same cycle.
- Lock (macro defined): ch2 sends a 3-beat packet with last on beat 3, ch7 valid throughout -> out_sel=2,2,2,7; in_ready[7]=0 until ch2's last beat is accepted.
- Mid-operation reset: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, ptr=0, lock FSM in IDLE.
